fifo_burst_reader: RTL and testbench
====================================

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: beat width in bits.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 32: depth of the attached FIFO, which sets the occupancy width.
REQ-003 The block SHALL have parameter BURST_LEN, default 8: maximum beats per burst, legal range 1..FIFO_DEPTH.
REQ-004 The block SHALL have parameter TIMEOUT, default 64: idle cycles before a partial burst is flushed, legal value >=1.
REQ-005 The block SHALL have parameter ADDR_WIDTH = $clog2(FIFO_DEPTH), which is derived and not configured.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port fifo_data_i, input, DATA_WIDTH bits: head entry of a first-word-fall-through FIFO.
REQ-009 The block SHALL have port fifo_empty_i, input, 1 bit: FIFO empty flag.
REQ-010 The block SHALL have port fifo_counter_i, input, ADDR_WIDTH+1 bits: FIFO occupancy.
REQ-011 The block SHALL have port fifo_rd_valid_o, output, 1 bit: pop request to the FIFO.
REQ-012 The block SHALL have port m_data_o, output, DATA_WIDTH bits: downstream beat data.
REQ-013 The block SHALL have port m_valid_o, output, 1 bit: downstream beat valid.
REQ-014 The block SHALL have port m_ready_i, input, 1 bit: downstream ready.
REQ-015 The block SHALL have port m_last_o, output, 1 bit: final beat of the burst.
REQ-016 The block SHALL have port m_len_o, output, $clog2(BURST_LEN+1) bits: length of the current burst, held for the whole burst.
REQ-017 The block SHALL have port busy_o, output, 1 bit: high when the FSM is in state BURST.

Function
REQ-018 The FSM SHALL have two states, IDLE and BURST.
REQ-019 In IDLE, if fifo_counter_i >= BURST_LEN, the FSM SHALL go to BURST next cycle and latch len = BURST_LEN.
REQ-020 In IDLE, the timeout counter SHALL increment each cycle while 0 < fifo_counter_i < BURST_LEN, and clear when fifo_empty_i=1 or when a burst starts.
REQ-021 In IDLE, when the timeout counter reaches TIMEOUT-1 with the FIFO non-empty, the FSM SHALL go to BURST and latch len = fifo_counter_i.
REQ-022 If the full-burst condition and the timeout condition are true in the same cycle, the full-burst condition (len = BURST_LEN) SHALL take priority.
REQ-023 In BURST, fifo_rd_valid_o SHALL equal beats_rem!=0 & ~fifo_empty_i & (~m_valid_o | m_ready_i); this is the pop condition.
REQ-024 On a pop, m_data_o SHALL load fifo_data_i, m_valid_o SHALL be set, m_last_o SHALL be set to (beats_rem==1), and beats_rem SHALL decrement.
REQ-025 On a downstream handshake with no pop in the same cycle, m_valid_o SHALL clear; m_data_o and m_last_o SHALL hold their values until the next load.
REQ-026 m_data_o, m_valid_o and m_last_o SHALL stay stable while m_valid_o=1 and m_ready_i=0.
REQ-027 On a handshake with m_last_o=1, the FSM SHALL return to IDLE next cycle; the earliest next burst decision is the cycle after that.
REQ-028 Latency SHALL be: trigger condition at cycle T -> BURST at T+1 with first pop -> m_valid_o at T+2.
REQ-029 With m_ready_i held high, throughput SHALL be one beat per cycle.
REQ-030 Pops SHALL never exceed the latched len.
REQ-031 FIFO writes during a burst SHALL NOT change the latched len.
REQ-032 If fifo_empty_i=1 while beats_rem>0, no pop SHALL be issued; the FSM SHALL stall in BURST (protects against a FIFO reset by another agent).
REQ-033 Counter widths SHALL be: beats_rem $clog2(BURST_LEN+1) bits; timeout counter $clog2(TIMEOUT+1) bits; no wrap-around in either.

Reset
REQ-034 While rst=1 at a clk edge, the block SHALL go to state IDLE with beats_rem=0 and timeout counter=0.
REQ-035 During reset, m_valid_o, m_last_o, fifo_rd_valid_o and busy_o SHALL be 0, and m_len_o and m_data_o SHALL be all zeros.
REQ-036 Reset asserted mid-burst SHALL abandon the burst with no further pops; beats already popped are lost, and the FIFO is not touched.

Structure
REQ-037 The shared package fifo_pkg SHALL hold the IDLE/BURST state encodings and the width helpers for the len and timeout counters.
REQ-038 The output register stage SHALL be implemented inline; no sub-module is required.

Verification
REQ-039 The bench SHALL cover: BURST_LEN=8, 8 words pre-loaded, m_ready_i=1 -> 8 beats on consecutive cycles, m_len_o=8, m_last_o only on beat 8, first m_valid_o 2 cycles after trigger.
REQ-040 The bench SHALL cover: 3 words loaded, no further writes, TIMEOUT=64 -> burst starts after 64 idle cycles, m_len_o=3, m_last_o on beat 3.
REQ-041 The bench SHALL cover: 8-beat burst with m_ready_i toggling 1-0-1-0 -> no beat lost or duplicated, output stable while stalled, exactly 8 pops.
REQ-042 The bench SHALL cover: 20 words loaded, BURST_LEN=8 -> bursts of 8, 8, then a 4-beat timeout flush; data order preserved.
REQ-043 The bench SHALL cover: rst=1 on the 4th beat of a burst -> next cycle m_valid_o=0, busy_o=0, fifo_rd_valid_o=0, and the FSM is in IDLE.
REQ-044 The bench SHALL cover: the FIFO reaches 8 words on the same cycle as the timeout expiry at 5 words -> m_len_o=8.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the FIFO burst reader.
package fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Width of a counter that must hold 0..burst_len inclusive.
  function automatic int len_width(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

  function automatic int tmo_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/fifo_burst_reader.sv
// Drains a first-word-fall-through FIFO in bursts of up to BURST_LEN beats,
// flushing a partial burst after TIMEOUT idle cycles.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int FIFO_DEPTH = 32,
  parameter  int BURST_LEN  = 8,
  parameter  int TIMEOUT    = 64,
  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           fifo_data_i,
  input  logic                            fifo_empty_i,
  input  logic [ADDR_WIDTH:0]             fifo_counter_i,
  output logic                            fifo_rd_valid_o,
  output logic [DATA_WIDTH-1:0]           m_data_o,
  output logic                            m_valid_o,
  input  logic                            m_ready_i,
  output logic                            m_last_o,
  output logic [len_width(BURST_LEN)-1:0] m_len_o,
  output logic                            busy_o
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int LEN_W = len_width(BURST_LEN);
  localparam int TMO_W = tmo_width(TIMEOUT);

  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(BURST_LEN);
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(BURST_LEN);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t                  r_state;
  logic [LEN_W-1:0]        r_beats_rem;
  logic [LEN_W-1:0]        r_len;
  logic [TMO_W-1:0]        r_tmo_cnt;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_valid;
  logic                    r_last;

  logic w_full;
  logic w_partial;
  logic w_tmo_hit;
  logic w_pop;
  logic w_hs;

  assign w_full    = (fifo_counter_i >= FULL_LVL);
  assign w_partial = ~fifo_empty_i && (fifo_counter_i != '0);
  assign w_tmo_hit = w_partial && (r_tmo_cnt == TMO_LAST);
  assign w_hs      = r_valid && m_ready_i;

  // Gated by rst so a reset landing mid-burst never takes another word.
  assign w_pop = ~rst && (r_state == BURST) && (r_beats_rem != '0) &&
                 ~fifo_empty_i && (~r_valid || m_ready_i);

  assign fifo_rd_valid_o = w_pop;
  assign m_data_o        = r_data;
  assign m_valid_o       = r_valid;
  assign m_last_o        = r_last;
  assign m_len_o         = r_len;
  assign busy_o          = (r_state == BURST);

  // NOTE: all state uses non-blocking assignments so every register sees
  // pre-edge values; the datapath registers are reset as well because the
  // outputs must read zero while rst is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_beats_rem <= '0;
      r_len       <= '0;
      r_tmo_cnt   <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_full) begin
            r_state     <= BURST;
            r_len       <= LEN_FULL;
            r_beats_rem <= LEN_FULL;
            r_tmo_cnt   <= '0;
          end else if (w_tmo_hit) begin
            r_state     <= BURST;
            r_len       <= LEN_W'(fifo_counter_i);
            r_beats_rem <= LEN_W'(fifo_counter_i);
            r_tmo_cnt   <= '0;
          end else if (!w_partial) begin
            r_tmo_cnt   <= '0;
          end else begin
            // Stops at TMO_LAST: reaching it always fires the flush above.
            r_tmo_cnt   <= r_tmo_cnt + 1'b1;
          end
        end

        BURST: begin
          if (w_pop) begin
            r_data      <= fifo_data_i;
            r_valid     <= 1'b1;
            r_last      <= (r_beats_rem == LEN_W'(1));
            r_beats_rem <= r_beats_rem - 1'b1;
          end else if (w_hs) begin
            r_valid     <= 1'b0;
          end
          if (w_hs && r_last) begin
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: FWFT FIFO model, handshake monitor,
// and linear stimulus with hand-computed expectations.
module tb_fifo_burst_reader;
  import fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic [5:0]  fifo_cnt;
  logic        rd_valid;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [3:0]  m_len;
  logic        busy;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DATA_WIDTH(32),
    .FIFO_DEPTH(32),
    .BURST_LEN (8),
    .TIMEOUT   (64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_data_i    (fifo_data),
    .fifo_empty_i   (fifo_empty),
    .fifo_counter_i (fifo_cnt),
    .fifo_rd_valid_o(rd_valid),
    .m_data_o       (m_data),
    .m_valid_o      (m_valid),
    .m_ready_i      (m_ready),
    .m_last_o       (m_last),
    .m_len_o        (m_len),
    .busy_o         (busy)
  );

  // FWFT FIFO model: the stimulus owns writes, the pop process owns reads.
  logic [31:0] mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  assign fifo_data  = mem[rd_ptr[7:0]];
  assign fifo_cnt   = 6'(wr_ptr - rd_ptr);
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) if (rd_valid) rd_ptr <= rd_ptr + 1;

  // Monitor: records accepted beats and counts pops between edges.
  logic [31:0] beat_d [$];
  logic        beat_l [$];
  logic [3:0]  beat_n [$];
  int          pop_cnt = 0;

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      beat_d.push_back(m_data);
      beat_l.push_back(m_last);
      beat_n.push_back(m_len);
    end
    if (rd_valid) pop_cnt <= pop_cnt + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    mem[wr_ptr[7:0]] = d;
    wr_ptr++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int p0;

    rst     = 1'b1;
    m_ready = 1'b1;
    repeat (3) tick();
    check("rst_m_valid",  32'(m_valid),  0);
    check("rst_m_last",   32'(m_last),   0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_busy",     32'(busy),     0);
    check("rst_m_len",    32'(m_len),    0);
    check("rst_m_data",   m_data,        0);
    rst = 1'b0;
    repeat (2) tick();

    // Full burst of 8 with ready held high.
    base = beat_d.size();
    p0   = pop_cnt;
    for (int k = 0; k < 8; k++) push(32'h1000_0000 + 32'(k));
    tick();
    check("A_busy",       32'(busy),     1);
    check("A_valid_t1",   32'(m_valid),  0);
    check("A_rd_valid",   32'(rd_valid), 1);
    check("A_len",        32'(m_len),    8);
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("A_valid%0d", k), 32'(m_valid), 1);
      check($sformatf("A_data%0d", k),  m_data,       32'h1000_0000 + 32'(k));
      check($sformatf("A_last%0d", k),  32'(m_last),  (k == 7) ? 1 : 0);
    end
    tick();
    check("A_idle",       32'(busy),                  0);
    check("A_valid_end",  32'(m_valid),               0);
    check("A_pops",       32'(pop_cnt - p0),          8);
    check("A_beats",      32'(beat_d.size() - base),  8);

    // Three words flushed by the timeout.
    for (int k = 0; k < 3; k++) push(32'h2000_0000 + 32'(k));
    repeat (63) tick();
    check("B_busy_before", 32'(busy), 0);
    tick();
    check("B_busy_at_64",  32'(busy),  1);
    check("B_len",         32'(m_len), 3);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("B_valid%0d", k), 32'(m_valid), 1);
      check($sformatf("B_data%0d", k),  m_data,       32'h2000_0000 + 32'(k));
      check($sformatf("B_last%0d", k),  32'(m_last),  (k == 2) ? 1 : 0);
    end
    tick();
    check("B_idle", 32'(busy), 0);

    // Eight beats with ready toggling 0/1: each beat stalls once.
    base = beat_d.size();
    p0   = pop_cnt;
    for (int k = 0; k < 8; k++) push(32'h3000_0000 + 32'(k));
    tick();
    tick();
    check("C_first_valid", 32'(m_valid), 1);
    for (int i = 0; i < 16; i++) begin
      m_ready = (i % 2 == 1);
      tick();
      if (i % 2 == 0) begin
        check($sformatf("C_stall_valid%0d", i / 2), 32'(m_valid), 1);
        check($sformatf("C_stall_data%0d", i / 2),  m_data,       32'h3000_0000 + 32'(i / 2));
        check($sformatf("C_stall_last%0d", i / 2),  32'(m_last),  (i == 14) ? 1 : 0);
      end
    end
    m_ready = 1'b1;
    check("C_idle",  32'(busy),                 0);
    check("C_pops",  32'(pop_cnt - p0),         8);
    check("C_beats", 32'(beat_d.size() - base), 8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("C_bdata%0d", k), beat_d[base + k],       32'h3000_0000 + 32'(k));
      check($sformatf("C_blast%0d", k), 32'(beat_l[base + k]),  (k == 7) ? 1 : 0);
    end

    // Twenty words: 8 + 8 + timeout flush of 4.
    base = beat_d.size();
    p0   = pop_cnt;
    for (int k = 0; k < 20; k++) push(32'h4000_0000 + 32'(k));
    for (int c = 0; c < 400 && (beat_d.size() - base) < 20; c++) tick();
    check("D_beats", 32'(beat_d.size() - base), 20);
    check("D_pops",  32'(pop_cnt - p0),         20);
    check("D_idle",  32'(busy),                 0);
    for (int k = 0; k < 20 && base + k < beat_d.size(); k++) begin
      check($sformatf("D_data%0d", k), beat_d[base + k],      32'h4000_0000 + 32'(k));
      check($sformatf("D_last%0d", k), 32'(beat_l[base + k]), (k == 7 || k == 15 || k == 19) ? 1 : 0);
      check($sformatf("D_len%0d", k),  32'(beat_n[base + k]), (k < 16) ? 8 : 4);
    end

    // Fill reaches 8 on the very cycle the 5-word timeout expires.
    base = beat_d.size();
    for (int k = 0; k < 5; k++) push(32'h5000_0000 + 32'(k));
    repeat (63) tick();
    check("E_busy_before", 32'(busy), 0);
    for (int k = 5; k < 8; k++) push(32'h5000_0000 + 32'(k));
    tick();
    check("E_busy", 32'(busy),  1);
    check("E_len",  32'(m_len), 8);
    for (int c = 0; c < 50 && (beat_d.size() - base) < 8; c++) tick();
    check("E_beats", 32'(beat_d.size() - base), 8);
    for (int k = 0; k < 8 && base + k < beat_d.size(); k++) begin
      check($sformatf("E_data%0d", k), beat_d[base + k],      32'h5000_0000 + 32'(k));
      check($sformatf("E_last%0d", k), 32'(beat_l[base + k]), (k == 7) ? 1 : 0);
    end

    // Reset on the 4th beat, then the 4 leftover words flush on timeout.
    repeat (2) tick();
    p0 = pop_cnt;
    for (int k = 0; k < 8; k++) push(32'h6000_0000 + 32'(k));
    repeat (5) tick();
    check("F_beat4_data", m_data, 32'h6000_0003);
    rst = 1'b1;
    tick();
    check("F_valid",    32'(m_valid),      0);
    check("F_busy",     32'(busy),         0);
    check("F_rd_valid", 32'(rd_valid),     0);
    check("F_state",    32'(dut.r_state),  32'(IDLE));
    check("F_len",      32'(m_len),        0);
    check("F_data",     m_data,            0);
    check("F_pops",     32'(pop_cnt - p0), 4);
    rst  = 1'b0;
    base = beat_d.size();
    for (int c = 0; c < 200 && (beat_d.size() - base) < 4; c++) tick();
    check("F_flush_beats", 32'(beat_d.size() - base), 4);
    for (int k = 0; k < 4 && base + k < beat_d.size(); k++) begin
      check($sformatf("F_fdata%0d", k), beat_d[base + k],      32'h6000_0004 + 32'(k));
      check($sformatf("F_flast%0d", k), 32'(beat_l[base + k]), (k == 3) ? 1 : 0);
      check($sformatf("F_flen%0d", k),  32'(beat_n[base + k]), 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
